// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage arithmetic unit: format codes,
// operation codes, FSM states and small decode helpers.
package alu_pkg;

  localparam logic [3:0] R_TYPE  = 4'd0;
  localparam logic [3:0] I_TYPE  = 4'd1;
  localparam logic [3:0] IL_TYPE = 4'd2;
  localparam logic [3:0] IE_TYPE = 4'd3;
  localparam logic [3:0] S_TYPE  = 4'd4;
  localparam logic [3:0] B_TYPE  = 4'd5;
  localparam logic [3:0] J_TYPE  = 4'd6;
  localparam logic [3:0] JI_TYPE = 4'd7;
  localparam logic [3:0] U_TYPE  = 4'd8;
  localparam logic [3:0] UP_TYPE = 4'd9;

  localparam logic [6:0] M_FUNCT7 = 7'h01;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SLT,
    OP_SRA, OP_SLTU, OP_PASSB,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
    OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } fsm_state_t;

  function automatic logic is_div_op(input alu_op_t op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

  // Quotient-producing divides; the remaining divide ops return the remainder.
  function automatic logic is_quot_op(input alu_op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_md_unit_if.sv
// Operation/result bus of alu_md_unit. Both sides use valid/ready: a transfer
// happens on a rising edge where valid && ready; the sender holds data stable until then.
interface alu_md_unit_if import alu_pkg::*; #(
  parameter int XLEN = 32
) ();
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      fmt;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;
  fsm_state_t      dbg_state;

  modport master (
    output in_valid, fmt, funct3, funct7, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, busy, dbg_state
  );

  modport slave (
    input  in_valid, fmt, funct3, funct7, op_a, op_b, out_ready,
    output in_ready, out_valid, result, busy, dbg_state
  );
endinterface

// File: rtl/alu_md_dec.sv
// Combinational decoder: (fmt, funct3, funct7) to operation code plus
// multiply/divide class and operand signedness.
module alu_md_dec import alu_pkg::*; #(
  parameter bit ENABLE_M = 1'b1
) (
  input  logic [3:0] fmt,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output alu_op_t    alu_op,
  output logic       is_mul,
  output logic       is_div,
  output logic       a_signed,
  output logic       b_signed
);

  always_comb begin
    alu_op   = OP_ADD;
    is_mul   = 1'b0;
    is_div   = 1'b0;
    a_signed = 1'b0;
    b_signed = 1'b0;
    if (ENABLE_M && (fmt == R_TYPE) && (funct7 == M_FUNCT7)) begin
      case (funct3)
        3'd0: begin alu_op = OP_MUL;    is_mul = 1'b1; end
        3'd1: begin alu_op = OP_MULH;   is_mul = 1'b1; a_signed = 1'b1; b_signed = 1'b1; end
        3'd2: begin alu_op = OP_MULHSU; is_mul = 1'b1; a_signed = 1'b1; end
        3'd3: begin alu_op = OP_MULHU;  is_mul = 1'b1; end
        3'd4: begin alu_op = OP_DIV;    is_div = 1'b1; a_signed = 1'b1; b_signed = 1'b1; end
        3'd5: begin alu_op = OP_DIVU;   is_div = 1'b1; end
        3'd6: begin alu_op = OP_REM;    is_div = 1'b1; a_signed = 1'b1; b_signed = 1'b1; end
        default: begin alu_op = OP_REMU; is_div = 1'b1; end
      endcase
    end else if ((fmt == R_TYPE) || (fmt == I_TYPE)) begin
      case (funct3)
        // I-type has no subtract: imm[11:5] is part of the immediate there.
        3'd0: alu_op = ((fmt == R_TYPE) && funct7[5]) ? OP_SUB : OP_ADD;
        3'd1: alu_op = OP_SLL;
        3'd2: alu_op = OP_SLT;
        3'd3: alu_op = OP_SLTU;
        3'd4: alu_op = OP_XOR;
        3'd5: alu_op = funct7[5] ? OP_SRA : OP_SRL;
        3'd6: alu_op = OP_OR;
        default: alu_op = OP_AND;
      endcase
    end else if (fmt == U_TYPE) begin
      alu_op = OP_PASSB;
    end
  end

endmodule

// File: rtl/alu_md_unit.sv
// Execute-stage arithmetic unit: single-cycle base ops, iterative shift-add
// multiply and restoring divide over XLEN cycles, handshaked on both sides.
module alu_md_unit import alu_pkg::*; #(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input logic          clk,
  input logic          rst,
  alu_md_unit_if.slave bus
);

  localparam int SW = $clog2(XLEN);

  fsm_state_t        state_q, state_d;
  logic [SW-1:0]     cnt_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opnd_q;
  alu_op_t           op_q;
  logic              neg_q;
  logic [XLEN-1:0]   result_q;

  alu_op_t dec_op;
  logic    dec_mul, dec_div, dec_sa, dec_sb;

  alu_md_dec #(.ENABLE_M(ENABLE_M)) u_dec (
    .fmt      (bus.fmt),
    .funct3   (bus.funct3),
    .funct7   (bus.funct7),
    .alu_op   (dec_op),
    .is_mul   (dec_mul),
    .is_div   (dec_div),
    .a_signed (dec_sa),
    .b_signed (dec_sb)
  );

  logic [XLEN-1:0] a, b;
  logic            accept;
  assign a      = bus.op_a;
  assign b      = bus.op_b;
  assign accept = bus.in_valid && (state_q == ST_IDLE);

  // Accept-time datapath: base result, divide shortcuts, operand magnitudes
  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] base_res, sc_res, mag_a, mag_b;
  logic            sign_a, sign_b, div_zero, div_ovf, shortcut;

  assign shamt    = b[SW-1:0];
  assign sign_a   = dec_sa & a[XLEN-1];
  assign sign_b   = dec_sb & b[XLEN-1];
  assign mag_a    = sign_a ? -a : a;
  assign mag_b    = sign_b ? -b : b;
  assign div_zero = (b == '0);
  assign div_ovf  = dec_sa && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
  assign shortcut = dec_div && (div_zero || div_ovf);

  always_comb begin
    base_res = a + b;
    case (dec_op)
      OP_SUB:   base_res = a - b;
      OP_AND:   base_res = a & b;
      OP_OR:    base_res = a | b;
      OP_XOR:   base_res = a ^ b;
      OP_SLL:   base_res = a << shamt;
      OP_SRL:   base_res = a >> shamt;
      OP_SRA:   base_res = $signed(a) >>> shamt;
      OP_SLT:   base_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU:  base_res = {{(XLEN-1){1'b0}}, (a < b)};
      OP_PASSB: base_res = b;
      default:  base_res = a + b;
    endcase
  end

  always_comb begin
    sc_res = '0;
    if (div_zero) sc_res = is_quot_op(dec_op) ? '1 : a;
    else          sc_res = is_quot_op(dec_op) ? a : '0;
  end

  // Iteration step. Multiply: acc = {partial high, remaining multiplier},
  // shifted right each cycle. Divide: acc = {remainder, dividend/quotient},
  // shifted left each cycle.
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic              div_ge;
  logic [XLEN-1:0]   div_rem;
  logic [2*XLEN-1:0] step, prod;
  logic [XLEN-1:0]   quo, rem, final_res;

  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd_q});
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_rem   = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
  assign step      = is_div_op(op_q) ? {div_rem, acc_q[XLEN-2:0], div_ge}
                                     : {mul_sum, acc_q[XLEN-1:1]};

  assign prod = neg_q ? -step : step;
  assign quo  = step[XLEN-1:0];
  assign rem  = step[2*XLEN-1:XLEN];

  always_comb begin
    final_res = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    if (is_div_op(op_q)) begin
      if (is_quot_op(op_q)) final_res = neg_q ? -quo : quo;
      else                  final_res = neg_q ? -rem : rem;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ((dec_mul || dec_div) && !shortcut) ? ST_CALC : ST_DONE;
      ST_CALC: if (cnt_q == SW'(XLEN-1)) state_d = ST_DONE;
      ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      op_q     <= OP_ADD;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q  <= dec_op;
            cnt_q <= '0;
            if (dec_div) begin
              acc_q  <= {{XLEN{1'b0}}, mag_a};
              opnd_q <= mag_b;
              neg_q  <= is_quot_op(dec_op) ? (sign_a ^ sign_b) : sign_a;
            end else begin
              acc_q  <= {{XLEN{1'b0}}, mag_b};
              opnd_q <= mag_a;
              neg_q  <= sign_a ^ sign_b;
            end
            if (shortcut)      result_q <= sc_res;
            else if (!dec_mul && !dec_div) result_q <= base_res;
          end
        end
        ST_CALC: begin
          acc_q <= step;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == SW'(XLEN-1)) result_q <= final_res;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q == ST_CALC);
  assign bus.result    = result_q;
  assign bus.dbg_state = state_q;

endmodule
